// File: rtl/line_tap_buffer.sv
// Multi-row line buffer: NUM_TAPS-row pixel column, 1-cycle latency, no backpressure (1 px/cycle).
// Optional LINE_TAP_BUFFER_ZERO_PAD_EN zeroes taps from rows not yet filled in the frame.
module line_tap_buffer #(
  parameter int ROW_SIZE   = 1280,
  parameter int PIXEL_SIZE = 12,
  parameter int NUM_TAPS   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             sof,
  input  logic [PIXEL_SIZE-1:0]            pixel,
  output logic                             out_valid,
  output logic [NUM_TAPS*PIXEL_SIZE-1:0]   taps,
  output logic [$clog2(ROW_SIZE)-1:0]      col,
  output logic                             window_valid
);
  localparam int CW = $clog2(ROW_SIZE);
  localparam int FW = $clog2(NUM_TAPS);
  localparam int NS = NUM_TAPS - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(NUM_TAPS - 1);

  logic [CW-1:0]         col_cnt, cur_col, wr_addr;
  logic [FW-1:0]         fill_cnt, cur_fill;
  logic                  wr_pend, byp, clr;
  logic [PIXEL_SIZE-1:0] pix_q;
  logic [PIXEL_SIZE-1:0] tap_raw [NUM_TAPS];
`ifdef LINE_TAP_BUFFER_ZERO_PAD_EN
  logic [FW-1:0]         fill_q;
`endif

  assign cur_col  = sof ? '0 : col_cnt;
  assign cur_fill = sof ? '0 : fill_cnt;
  assign tap_raw[0] = pix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      window_valid <= 1'b0;
      col          <= '0;
      col_cnt      <= '0;
      fill_cnt     <= '0;
      wr_addr      <= '0;
      wr_pend      <= 1'b0;
      byp          <= 1'b0;
      clr          <= 1'b1;
      pix_q        <= '0;
`ifdef LINE_TAP_BUFFER_ZERO_PAD_EN
      fill_q       <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      wr_pend   <= in_valid;
      if (in_valid) begin
        col          <= cur_col;
        wr_addr      <= cur_col;
        window_valid <= (cur_fill == FILL_MAX);
        pix_q        <= pixel;
        clr          <= 1'b0;
        // Back-to-back hit on the column still waiting to be written: forward it.
        byp          <= wr_pend && (wr_addr == cur_col);
`ifdef LINE_TAP_BUFFER_ZERO_PAD_EN
        fill_q       <= cur_fill;
`endif
        if (cur_col == COL_LAST) begin
          col_cnt  <= '0;
          fill_cnt <= (cur_fill != FILL_MAX) ? cur_fill + 1'b1 : cur_fill;
        end else begin
          col_cnt  <= cur_col + 1'b1;
          fill_cnt <= cur_fill;
        end
      end
    end
  end

  // Store j is written one cycle after the read, with the value now on tap j,
  // which is exactly the old content of store j-1 (or the pixel for store 0).
  for (genvar j = 0; j < NS; j++) begin : g_store
    logic [PIXEL_SIZE-1:0] mem [ROW_SIZE];
    logic [PIXEL_SIZE-1:0] rd_q;
    logic [PIXEL_SIZE-1:0] byp_dat;

    always_ff @(posedge clk) begin
      if (wr_pend) mem[wr_addr] <= tap_raw[j];
      if (in_valid && !rst) rd_q <= mem[cur_col];
    end

    always_ff @(posedge clk) begin
      if (in_valid && !rst) byp_dat <= tap_raw[j];
    end

    assign tap_raw[j+1] = clr ? '0 : (byp ? byp_dat : rd_q);
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_out
`ifdef LINE_TAP_BUFFER_ZERO_PAD_EN
    assign taps[k*PIXEL_SIZE +: PIXEL_SIZE] = (k > int'(fill_q)) ? '0 : tap_raw[k];
`else
    assign taps[k*PIXEL_SIZE +: PIXEL_SIZE] = tap_raw[k];
`endif
  end
endmodule
